bus_timer_responder: RTL and testbench
======================================

BUS_TIMER_RESPONDER -- requirements
Module: bus_timer_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000: base of 32-byte register window; bits [4:0] ignored.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port bus_addr  input  32  byte address from core.
REQ-005 SHALL have port bus_wrdata  input  32  write data from core.
REQ-006 SHALL have port bus_wren  input  1  write strobe, one access per asserted cycle.
REQ-007 SHALL have port bus_rden  input  1  read strobe.
REQ-008 SHALL have port bus_rddata  output  32  read data to core.
REQ-009 SHALL have port bus_sel  output  1  address hits this window.
REQ-010 SHALL have port irq  output  1  level interrupt request.

Function
REQ-011 SHALL assert bus_sel combinationally when bus_addr[31:5] == BASE_ADDR[31:5].
REQ-012 SHALL decode word offset bus_addr[4:2]: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE, 4 STATUS; offsets 5-7 read 0, writes ignored.
REQ-013 SHALL ignore bus_addr[1:0]; every write stores full bus_wrdata (no byte lanes).
REQ-014 CTRL SHALL be 3 bits: [0] enable, [1] auto_reload, [2] irq_en; upper bits read 0.
REQ-015 PRESCALE SHALL be 16 bits, read zero-extended; COUNT and COMPARE SHALL be 32 bits.
REQ-016 STATUS[0] SHALL be sticky match flag; writing 1 clears it, writing 0 leaves it unchanged.
REQ-017 bus_rddata SHALL be combinational, zero-latency: selected register when bus_rden & bus_sel, else 32'h0.
REQ-018 Writes SHALL take effect at the rising edge of the cycle in which bus_wren & bus_sel; no read side effects.
REQ-019 Internal 16-bit prescale counter pcnt SHALL increment each cycle while enable=1; when pcnt == PRESCALE, a tick occurs and pcnt returns to 0.
REQ-020 PRESCALE=0 SHALL yield a tick every enabled cycle; PRESCALE=N SHALL yield one tick per N+1 cycles.
REQ-021 On tick, if COUNT == COMPARE: set match flag; COUNT <= 0 when auto_reload=1, else COUNT+1.
REQ-022 On tick without match, COUNT SHALL increment modulo 2^32 (32'hFFFF_FFFF -> 0, no flag).
REQ-023 enable=0 SHALL freeze pcnt and COUNT at current values.
REQ-024 Software write to COUNT in a tick cycle SHALL win; tick increment and match evaluation discarded that cycle.
REQ-025 Write to PRESCALE SHALL also clear pcnt to 0.
REQ-026 Match set and STATUS write-1-clear in same cycle: set SHALL win (flag stays 1).
REQ-027 irq SHALL equal STATUS[0] & CTRL[2], driven from registers (no combinational path from bus inputs).

Reset
REQ-028 While rst=0: CTRL, PRESCALE, COUNT, COMPARE, STATUS and pcnt SHALL clear to 0 immediately, irq=0.
REQ-029 Reset asserted mid-count SHALL abandon pending tick; counting resumes only after software sets enable.
REQ-030 bus_rddata and bus_sel SHALL remain combinational during reset (registers read 0).

Verification
REQ-031 Reset then read offsets 0-7 at BASE_ADDR -> all return 32'h0, irq=0.
REQ-032 PRESCALE=2, COMPARE=3, CTRL=3'b111 -> COUNT increments every 3rd cycle; on tick with COUNT==3 STATUS=1, COUNT->0, irq=1 next edge.
REQ-033 PRESCALE=0, COUNT=32'hFFFF_FFFE, COMPARE=5, CTRL=1 -> COUNT reads FFFF_FFFF, then 0, then 1 on consecutive cycles; STATUS stays 0.
REQ-034 Write COUNT=32'h100 in same cycle as tick -> COUNT reads 32'h100 next cycle, no flag set.
REQ-035 STATUS write 1 coincident with match tick -> STATUS stays 1; write 1 on later idle cycle -> STATUS=0, irq=0.
REQ-036 Access to BASE_ADDR+32'h20 with bus_rden=1 -> bus_sel=0, bus_rddata=0; write there leaves all registers unchanged.

Source files
------------

// File: rtl/bus_timer_responder_if.sv
// Bus bundle between a core (master) and the timer register window (slave).
`timescale 1ns/1ps

interface bus_timer_responder_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wrdata;
    logic        bus_wren;
    logic        bus_rden;
    logic [31:0] bus_rddata;
    logic        bus_sel;

    modport master (
        output bus_addr,
        output bus_wrdata,
        output bus_wren,
        output bus_rden,
        input  bus_rddata,
        input  bus_sel
    );

    modport slave (
        input  bus_addr,
        input  bus_wrdata,
        input  bus_wren,
        input  bus_rden,
        output bus_rddata,
        output bus_sel
    );
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped prescaled timer with compare match flag and level interrupt.
// Register window (word offsets): 0 CTRL, 1 PRESCALE, 2 COUNT, 3 COMPARE, 4 STATUS.
`timescale 1ns/1ps

module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    bus_timer_responder_if.slave        bus,
    output logic                        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_PRESCALE = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_COMPARE  = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [2:0]  ctrl_q;
    logic [15:0] prescale_q;
    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        status_q;
    logic [15:0] pcnt_q;

    logic        sel;
    logic [2:0]  word_off;
    logic        wr_hit;
    logic        wr_ctrl;
    logic        wr_prescale;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        enable;
    logic        auto_reload;
    logic        irq_en;
    logic        tick;
    logic        match_set;
    logic        unused_addr_bits;

    // Address bits [1:0] carry no meaning for this word-only window.
    assign unused_addr_bits = ^bus.bus_addr[1:0];

    assign sel      = (bus.bus_addr[31:5] == BASE_ADDR[31:5]);
    assign word_off = bus.bus_addr[4:2];
    assign wr_hit   = bus.bus_wren & sel;

    assign wr_ctrl     = wr_hit && (word_off == OFF_CTRL);
    assign wr_prescale = wr_hit && (word_off == OFF_PRESCALE);
    assign wr_count    = wr_hit && (word_off == OFF_COUNT);
    assign wr_compare  = wr_hit && (word_off == OFF_COMPARE);
    assign wr_status   = wr_hit && (word_off == OFF_STATUS);

    assign enable      = ctrl_q[0];
    assign auto_reload = ctrl_q[1];
    assign irq_en      = ctrl_q[2];

    // A software write to COUNT discards the tick's effect, including match detection.
    assign tick      = enable && (pcnt_q == prescale_q);
    assign match_set = tick && (count_q == compare_q) && !wr_count;

    assign bus.bus_sel = sel;
    assign irq         = status_q & irq_en;

    // Combinational read mux; unmapped offsets and non-read cycles return zero.
    always_comb begin
        bus.bus_rddata = 32'h0;
        if (bus.bus_rden && sel) begin
            case (word_off)
                OFF_CTRL:     bus.bus_rddata = {29'h0, ctrl_q};
                OFF_PRESCALE: bus.bus_rddata = {16'h0, prescale_q};
                OFF_COUNT:    bus.bus_rddata = count_q;
                OFF_COMPARE:  bus.bus_rddata = compare_q;
                OFF_STATUS:   bus.bus_rddata = {31'h0, status_q};
                default:      bus.bus_rddata = 32'h0;
            endcase
        end
    end

    // Control and configuration registers written straight from the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= 3'b000;
            prescale_q <= 16'h0;
            compare_q  <= 32'h0;
        end else begin
            if (wr_ctrl) begin
                ctrl_q <= bus.bus_wrdata[2:0];
            end
            if (wr_prescale) begin
                prescale_q <= bus.bus_wrdata[15:0];
            end
            if (wr_compare) begin
                compare_q <= bus.bus_wrdata;
            end
        end
    end

    // Prescale counter; restarts whenever a new prescale value is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt_q <= 16'h0;
        end else if (wr_prescale) begin
            pcnt_q <= 16'h0;
        end else if (enable) begin
            pcnt_q <= tick ? 16'h0 : pcnt_q + 16'd1;
        end
    end

    // Main counter; software writes override tick updates in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= 32'h0;
        end else if (wr_count) begin
            count_q <= bus.bus_wrdata;
        end else if (tick) begin
            if ((count_q == compare_q) && auto_reload) begin
                count_q <= 32'h0;
            end else begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Sticky match flag; a new match beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= 1'b0;
        end else if (match_set) begin
            status_q <= 1'b1;
        end else if (wr_status && bus.bus_wrdata[0]) begin
            status_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_timer_responder.sv
// Scoreboard bench for bus_timer_responder: directed bus cycles push expected
// read responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_bus_timer_responder;

    localparam logic [31:0] BASE   = 32'h1001_0000;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_CMP  = BASE + 32'hC;
    localparam logic [31:0] A_STAT = BASE + 32'h10;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        sel;
        logic        irq;
    } exp_t;

    logic clk;
    logic rst;
    logic irq;
    int   total;
    int   bad;
    exp_t exp_q[$];

    bus_timer_responder_if bus_if ();

    bus_timer_responder #(.BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .irq (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // One bus cycle starting just after a rising edge; reads queue their expectation.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic wren, input logic rden,
                                 input logic [31:0] exp_data, input logic exp_sel,
                                 input logic exp_irq, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        bus_if.bus_addr   = addr;
        bus_if.bus_wrdata = wdata;
        bus_if.bus_wren   = wren;
        bus_if.bus_rden   = rden;
        if (rden) begin
            e.name = name;
            e.data = exp_data;
            e.sel  = exp_sel;
            e.irq  = exp_irq;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(addr, data, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "write");
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_irq, input string name);
        applyStimulus(addr, 32'h0, 1'b0, 1'b1, data, 1'b1, exp_irq, name);
    endtask

    task automatic idle();
        applyStimulus(BASE + 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "idle");
    endtask

    // Compare one presented read response against its queued expectation.
    task automatic checkOutput(input exp_t e);
        total++;
        if (bus_if.bus_rddata !== e.data) begin
            bad++;
            $display("[TB] FAIL %s rddata: got %h required %h", e.name, bus_if.bus_rddata, e.data);
        end
        total++;
        if (bus_if.bus_sel !== e.sel) begin
            bad++;
            $display("[TB] FAIL %s sel: got %b required %b", e.name, bus_if.bus_sel, e.sel);
        end
        total++;
        if (irq !== e.irq) begin
            bad++;
            $display("[TB] FAIL %s irq: got %b required %b", e.name, irq, e.irq);
        end
    endtask

    // Monitor: every cycle with a read strobe presents a response mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.bus_rden === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_read: got response %h, required none queued", bus_if.bus_rddata);
                end else begin
                    checkOutput(exp_q.pop_front());
                end
            end
        end
    end

    // Directed scenarios.
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus_if.bus_addr   = 32'h0;
        bus_if.bus_wrdata = 32'h0;
        bus_if.bus_wren   = 1'b0;
        bus_if.bus_rden   = 1'b0;

        // Reads while held in reset, then the whole window after release.
        rd(A_CTRL, 32'h0, 1'b0, "in_reset_ctrl");
        rd(A_CNT,  32'h0, 1'b0, "in_reset_count");
        idle();
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(BASE + 32'(i * 4) + 32'(i % 4), 32'h0, 1'b0, "reset_window");
        end

        // Prescale 2, compare 3, auto reload with irq.
        wr(A_PRE, 32'd2);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h7);
        for (int i = 0; i < 12; i++) begin
            rd(A_CNT, 32'(i / 3), 1'b0, "count_prescale2");
        end
        rd(A_CNT,  32'h0, 1'b1, "auto_reload");
        rd(A_STAT, 32'h1, 1'b1, "match_flag");
        wr(A_CTRL, 32'h0);
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'h0, 1'b0, "status_cleared");

        // Wraparound at 2^32 without a flag, then freeze on disable.
        wr(A_PRE, 32'h0);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h1);
        rd(A_CNT, 32'hFFFF_FFFE, 1'b0, "wrap_fe");
        rd(A_CNT, 32'hFFFF_FFFF, 1'b0, "wrap_ff");
        rd(A_CNT, 32'h0000_0000, 1'b0, "wrap_0");
        rd(A_CNT, 32'h0000_0001, 1'b0, "wrap_1");
        rd(A_STAT, 32'h0, 1'b0, "wrap_no_flag");
        wr(A_CTRL, 32'h0);
        rd(A_CNT, 32'd4, 1'b0, "frozen_a");
        rd(A_CNT, 32'd4, 1'b0, "frozen_b");

        // Software COUNT write beats a matching tick.
        wr(A_CMP, 32'd7);
        wr(A_CNT, 32'd7);
        wr(A_CTRL, 32'h1);
        wr(A_CNT, 32'h100);
        rd(A_CNT, 32'h100, 1'b0, "count_write_wins");
        rd(A_STAT, 32'h0, 1'b0, "count_write_no_flag");
        wr(A_CTRL, 32'h0);
        rd(A_CNT, 32'h103, 1'b0, "count_after_write");

        // Match set beats coincident clear; write 0 keeps, later write 1 clears.
        wr(A_CMP, 32'h10);
        wr(A_CNT, 32'h10);
        wr(A_CTRL, 32'h7);
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'h1, 1'b1, "set_beats_clear");
        wr(A_STAT, 32'h0);
        rd(A_STAT, 32'h1, 1'b1, "write0_keeps");
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'h0, 1'b0, "idle_clear");
        wr(A_CTRL, 32'h0);

        // Field widths, unmapped offsets and out-of-window accesses.
        wr(A_PRE, 32'hABCD_1234);
        wr(A_CTRL, 32'hFFFF_FFFC);
        rd(A_PRE,  32'h0000_1234, 1'b0, "prescale_zext");
        rd(A_CTRL, 32'h0000_0004, 1'b0, "ctrl_width");
        applyStimulus(BASE + 32'h20, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, "oow_read");
        applyStimulus(BASE + 32'h20, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "oow_wr");
        applyStimulus(BASE + 32'h24, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "oow_wr");
        applyStimulus(BASE + 32'h28, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, "oow_wr");
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        rd(BASE + 32'h14, 32'h0, 1'b0, "offset5_reads0");
        rd(A_PRE,  32'h0000_1234, 1'b0, "oow_prescale_kept");
        rd(A_CTRL, 32'h0000_0004, 1'b0, "oow_ctrl_kept");
        rd(A_CNT + 32'h3, 32'd6, 1'b0, "oow_count_kept");
        rd(A_CMP + 32'h2, 32'h10, 1'b0, "oow_compare_kept");

        // Reset mid-count clears everything including a raised irq.
        wr(A_PRE, 32'h0);
        wr(A_CMP, 32'h0);
        wr(A_CNT, 32'h0);
        wr(A_CTRL, 32'h7);
        idle();
        rd(A_STAT, 32'h1, 1'b1, "pre_reset_irq");
        idle();
        #1 rst = 1'b0;
        rd(A_CTRL, 32'h0, 1'b0, "mid_reset_ctrl");
        rd(A_STAT, 32'h0, 1'b0, "mid_reset_status");
        rd(A_CNT,  32'h0, 1'b0, "mid_reset_count");
        rd(A_PRE,  32'h0, 1'b0, "mid_reset_prescale");
        rd(A_CMP,  32'h0, 1'b0, "mid_reset_compare");
        idle();
        #2 rst = 1'b1;
        idle();
        idle();
        rd(A_CNT,  32'h0, 1'b0, "post_reset_no_count");
        rd(A_STAT, 32'h0, 1'b0, "post_reset_status");
        idle();
        idle();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
